if_stage: RTL



---
 rtl/if_stage_pkg.sv | 15 +
 rtl/inst_queue.sv | 81 ++++++++
 rtl/if_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: widths, reset constants and fetch FSM encoding.
package if_stage_pkg;

  localparam int          AddrLen   = 32;
  localparam int          InstLen   = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [31:0] ResetPc   = 32'h0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_FETCH   = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_queue.sv
// Two-entry {pc, inst} FIFO between fetch and decode; clear beats push/pop.
module inst_queue #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [1:0]        count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic [PC_W-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [1:0]        count_q, count_d;

  // Slot 0 is always the head; a pop shifts slot 1 forward.
  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_i) begin
      if (count_q == 2'd2) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
        pc1_d   = pc_i;
        inst1_d = inst_i;
      end else begin
        pc0_d   = pc_i;
        inst0_d = inst_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        pc0_d   = pc_i;
        inst0_d = inst_i;
      end else begin
        pc1_d   = pc_i;
        inst1_d = inst_i;
      end
      count_d = count_q + 2'd1;
    end else if (pop_i && count_q != 2'd0) begin
      pc0_d   = pc1_q;
      inst0_d = inst1_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      inst0_q <= '0;
      inst1_q <= '0;
      count_q <= 2'd0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign pc_o    = pc0_q;
  assign inst_o  = inst0_q;

endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: byte-serial instruction fetch, little-endian assembly,
// redirect handling with wrong-path discard, feeding a 2-entry queue.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = AddrLen,
  parameter int                INST_W   = InstLen,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ResetPc)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              inst_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  if_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              memReq_q, memReq_d;

  logic              qPush, qPop, qClear, qEmpty, qFull, popEn;
  logic              freeAfterPop, freeAfterPush;
  logic [1:0]        qCount;
  logic [INST_W-1:0] word;

  assign word          = {mem_rdata, buf_q};
  assign popEn         = inst_valid_o & id_ready_i;
  assign qPop          = rdy & popEn;
  assign freeAfterPop  = !qFull || popEn;
  assign freeAfterPush = (qCount == 2'd0) || (qCount == 2'd1 && popEn);

  // The in-flight word owns a reserved slot, so the launch decision is the only overflow guard.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    fetchPc_d = fetchPc_q;
    memAddr_d = memAddr_q;
    qPush     = 1'b0;
    qClear    = 1'b0;
    if (rdy) begin
      if (jump_i) begin
        qClear    = 1'b1;
        fetchPc_d = {jump_addr_i[ADDR_W-1:2], 2'b00};
      end
      unique case (state_q)
        IF_IDLE: begin
          if (!jump_i && freeAfterPop) begin
            state_d   = IF_FETCH;
            memAddr_d = fetchPc_q;
          end
        end
        default: begin
          if (state_q == IF_FETCH && jump_i) state_d = IF_DISCARD;
          if (mem_rvalid) begin
            if (cnt_q != 2'd3) begin
              unique case (cnt_q)
                2'd0:    buf_d[7:0]   = mem_rdata;
                2'd1:    buf_d[15:8]  = mem_rdata;
                default: buf_d[23:16] = mem_rdata;
              endcase
              cnt_d     = cnt_q + 2'd1;
              memAddr_d = memAddr_q + ADDR_W'(1);
            end else begin
              cnt_d = 2'd0;
              if (state_q == IF_FETCH) begin
                if (jump_i) begin
                  state_d = IF_IDLE;
                end else begin
                  qPush     = 1'b1;
                  fetchPc_d = fetchPc_q + ADDR_W'(4);
                  state_d   = freeAfterPush ? IF_FETCH : IF_IDLE;
                end
              end else begin
                state_d = (jump_i || freeAfterPop) ? IF_FETCH : IF_IDLE;
              end
              memAddr_d = fetchPc_d;
            end
          end
        end
      endcase
    end
    memReq_d = (state_d != IF_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IF_IDLE;
      cnt_q     <= 2'd0;
      buf_q     <= 24'h0;
      fetchPc_q <= RESET_PC;
      memAddr_q <= ADDR_W'(ZERO_WORD);
      memReq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      fetchPc_q <= fetchPc_d;
      memAddr_q <= memAddr_d;
      memReq_q  <= memReq_d;
    end
  end

  assign mem_req      = memReq_q;
  assign mem_addr     = memAddr_q;
  assign inst_valid_o = !qEmpty;

  inst_queue #(
    .PC_W   (ADDR_W),
    .INST_W (INST_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (qClear),
    .push_i  (qPush),
    .pop_i   (qPop),
    .pc_i    (fetchPc_q),
    .inst_i  (word),
    .count_o (qCount),
    .empty_o (qEmpty),
    .full_o  (qFull),
    .pc_o    (pc_o),
    .inst_o  (inst_o)
  );

endmodule
